rv_decode_stage: RTL and testbench

//  Registered RV32I decode stage between instruction fetch and the ALU. Splits a fetched word into opcode/func3/func7/shamt,

---
 rtl/rv_decode_stage_if.sv | 43 ++++
 rtl/rv_decode_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side signals of the RV32I decode stage, bundled as one port.
interface rv_decode_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      rd;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            jump;
  logic            illegal;

  modport slave (
    input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, opcode, func3, func7, shamt,
           alu_a, alu_b, imm, out_pc, rd, reg_write, mem_read, mem_write,
           branch, jump, illegal
  );

  modport master (
    output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, opcode, func3, func7, shamt,
           alu_a, alu_b, imm, out_pc, rd, reg_write, mem_read, mem_write,
           branch, jump, illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: field split, immediate build, ALU operand select
// and control flags, behind a single-entry valid/ready output register.
module rv_decode_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  rv_decode_stage_if.slave bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  state_t          state_r;
  state_t          state_nx;
  bundle_t         dec_s;
  bundle_t         bundle_r;
  logic            accept_s;
  logic            in_ready_s;
  logic            is_shift_s;
  logic            rw_s;
  logic [6:0]      op_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] imm_j_s;

  assign op_s       = bus.instr[6:0];
  assign is_shift_s = (bus.instr[13:12] == 2'b01);
  assign imm_i_s    = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s_s    = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_b_s    = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                       bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign imm_u_s    = {bus.instr[31:12], 12'h000};
  assign imm_j_s    = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                       bus.instr[20], bus.instr[30:21], 1'b0};

  // Flush wins over everything, so a flushed cycle never accepts.
  assign in_ready_s   = ~bus.flush & ((state_r == EMPTY) | bus.out_ready);
  assign accept_s     = bus.in_valid & in_ready_s;
  assign bus.in_ready = in_ready_s;
  assign bus.rs1_addr = bus.instr[19:15];
  assign bus.rs2_addr = bus.instr[24:20];

  // Combinational decode of the incoming word into a candidate bundle.
  always_comb begin
    dec_s       = '0;
    rw_s        = 1'b0;
    dec_s.func3 = bus.instr[14:12];
    dec_s.rd    = bus.instr[11:7];
    dec_s.pc    = bus.pc;
    dec_s.opcode = op_s;
    case (op_s)
      OP_LUI: begin
        dec_s.alu_b = imm_u_s;
        dec_s.imm   = imm_u_s;
        rw_s        = 1'b1;
      end
      OP_AUIPC: begin
        dec_s.alu_a = bus.pc;
        dec_s.alu_b = imm_u_s;
        dec_s.imm   = imm_u_s;
        rw_s        = 1'b1;
      end
      OP_JAL: begin
        dec_s.alu_a = bus.pc;
        dec_s.alu_b = imm_j_s;
        dec_s.imm   = imm_j_s;
        dec_s.jump  = 1'b1;
        rw_s        = 1'b1;
      end
      OP_JALR: begin
        dec_s.alu_a = bus.rs1_data;
        dec_s.alu_b = imm_i_s;
        dec_s.imm   = imm_i_s;
        dec_s.jump  = 1'b1;
        rw_s        = 1'b1;
      end
      OP_BRANCH: begin
        dec_s.alu_a  = bus.rs1_data;
        dec_s.alu_b  = bus.rs2_data;
        dec_s.imm    = imm_b_s;
        dec_s.branch = 1'b1;
      end
      OP_LOAD: begin
        dec_s.alu_a    = bus.rs1_data;
        dec_s.alu_b    = imm_i_s;
        dec_s.imm      = imm_i_s;
        dec_s.mem_read = 1'b1;
        rw_s           = 1'b1;
      end
      OP_STORE: begin
        dec_s.alu_a     = bus.rs1_data;
        dec_s.alu_b     = imm_s_s;
        dec_s.imm       = imm_s_s;
        dec_s.mem_write = 1'b1;
      end
      OP_IMM: begin
        dec_s.alu_a = bus.rs1_data;
        dec_s.alu_b = imm_i_s;
        dec_s.imm   = imm_i_s;
        rw_s        = 1'b1;
        if (is_shift_s) begin
          dec_s.func7 = bus.instr[31:25];
          dec_s.shamt = bus.instr[24:20];
        end else begin
          dec_s.func7 = 7'd0;
          dec_s.shamt = 5'd0;
        end
      end
      OP_REG: begin
        dec_s.alu_a = bus.rs1_data;
        dec_s.alu_b = bus.rs2_data;
        dec_s.func7 = bus.instr[31:25];
        rw_s        = 1'b1;
        // Register shifts take their amount from the rs2 value, not the encoding.
        if (is_shift_s) begin
          dec_s.shamt = bus.rs2_data[4:0];
        end else begin
          dec_s.shamt = 5'd0;
        end
      end
      default: begin
        dec_s.opcode  = 7'd0;
        dec_s.illegal = 1'b1;
      end
    endcase
    dec_s.reg_write = rw_s & (bus.instr[11:7] != 5'd0);
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next occupancy from accept, handoff and flush.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nx = FULL;
        end else begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (bus.flush) begin
          state_nx = EMPTY;
        end else if (accept_s) begin
          state_nx = FULL;
        end else if (bus.out_ready) begin
          state_nx = EMPTY;
        end else begin
          state_nx = FULL;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Output bundle register; only an accept may change it, keeping stalls bit-stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bundle_r    <= '0;
      bundle_r.pc <= RESET_PC;
    end else if (accept_s) begin
      bundle_r <= dec_s;
    end
  end

  assign bus.out_valid = (state_r == FULL);
  assign bus.opcode    = bundle_r.opcode;
  assign bus.func3     = bundle_r.func3;
  assign bus.func7     = bundle_r.func7;
  assign bus.shamt     = bundle_r.shamt;
  assign bus.alu_a     = bundle_r.alu_a;
  assign bus.alu_b     = bundle_r.alu_b;
  assign bus.imm       = bundle_r.imm;
  assign bus.out_pc    = bundle_r.pc;
  assign bus.rd        = bundle_r.rd;
  assign bus.reg_write = bundle_r.reg_write;
  assign bus.mem_read  = bundle_r.mem_read;
  assign bus.mem_write = bundle_r.mem_write;
  assign bus.branch    = bundle_r.branch;
  assign bus.jump      = bundle_r.jump;
  assign bus.illegal   = bundle_r.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed vector table, handshake corner sequences,
// and random traffic against a rule-level decode model with an occupancy scoreboard.
module tb_rv_decode_stage;

  localparam logic [31:0] RPC = 32'h0000_1000;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  shamt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    bundle_t     exp;
  } vec_t;

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  int      n_pass = 0;
  int      n_total = 0;
  logic    exp_full;
  bundle_t exp_b;
  bundle_t rst_b;
  vec_t    vecs[9];
  logic [6:0] ops[9];

  rv_decode_stage_if bus ();

  rv_decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic bundle_t observed();
    return '{bus.opcode, bus.func3, bus.func7, bus.shamt, bus.alu_a, bus.alu_b,
             bus.imm, bus.out_pc, bus.rd, bus.reg_write, bus.mem_read,
             bus.mem_write, bus.branch, bus.jump, bus.illegal};
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Reference decode: immediates by arithmetic right shift of the gathered field.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                         input logic [31:0] r1, input logic [31:0] r2);
    bundle_t b;
    logic signed [31:0] t;
    logic [31:0] ii, si, bi, ui, ji;
    logic writes;
    t  = w & 32'hFFF0_0000;                                   ii = 32'(t >>> 20);
    t  = {w[31:25], w[11:7], 20'd0};                          si = 32'(t >>> 20);
    t  = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'd0};       bi = 32'(t >>> 19);
    t  = {w[31], w[19:12], w[20], w[30:21], 1'b0, 11'd0};     ji = 32'(t >>> 11);
    ui = w & 32'hFFFF_F000;
    b = '0;
    b.opcode = w[6:0]; b.func3 = w[14:12]; b.rd = w[11:7]; b.pc = pc;
    writes = 1'b1;
    case (w[6:0])
      7'h37: begin b.alu_b = ui; b.imm = ui; end
      7'h17: begin b.alu_a = pc; b.alu_b = ui; b.imm = ui; end
      7'h6F: begin b.alu_a = pc; b.alu_b = ji; b.imm = ji; b.jump = 1'b1; end
      7'h67: begin b.alu_a = r1; b.alu_b = ii; b.imm = ii; b.jump = 1'b1; end
      7'h63: begin b.alu_a = r1; b.alu_b = r2; b.imm = bi; b.branch = 1'b1; writes = 1'b0; end
      7'h03: begin b.alu_a = r1; b.alu_b = ii; b.imm = ii; b.mem_read = 1'b1; end
      7'h23: begin b.alu_a = r1; b.alu_b = si; b.imm = si; b.mem_write = 1'b1; writes = 1'b0; end
      7'h13: begin
        b.alu_a = r1; b.alu_b = ii; b.imm = ii;
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin b.func7 = w[31:25]; b.shamt = w[24:20]; end
      end
      7'h33: begin
        b.alu_a = r1; b.alu_b = r2; b.func7 = w[31:25];
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) b.shamt = r2[4:0];
      end
      default: begin b.opcode = 7'd0; b.illegal = 1'b1; writes = 1'b0; end
    endcase
    b.reg_write = writes && (w[11:7] != 5'd0);
    return b;
  endfunction

  task automatic drive(input logic v, input logic rdy, input logic fl, input logic [31:0] w,
                       input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid = v; bus.out_ready = rdy; bus.flush = fl; bus.instr = w;
    bus.pc = pc; bus.rs1_data = r1; bus.rs2_data = r2;
  endtask

  // One clock of traffic checked against the occupancy scoreboard; call after a negedge.
  task automatic step();
    logic ready_e, acc;
    #1;
    ready_e = !bus.flush && (!exp_full || bus.out_ready);
    chk("in_ready", 192'(bus.in_ready), 192'(ready_e));
    chk("rs_addr", 192'({bus.rs1_addr, bus.rs2_addr}), 192'({bus.instr[19:15], bus.instr[24:20]}));
    acc = bus.in_valid && ready_e;
    if (bus.flush) exp_full = 1'b0;
    else if (acc) begin
      exp_full = 1'b1;
      exp_b = ref_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);
    end else if (bus.out_ready) exp_full = 1'b0;
    @(posedge clk); #1;
    chk("out_valid", 192'(bus.out_valid), 192'(exp_full));
    if (exp_full) chk("bundle", 192'(observed()), 192'(exp_b));
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{32'hFFD08293, 32'h000, 32'd10, 32'd0,
                '{7'h13, 3'd0, 7'h00, 5'd0, 32'd10, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'h40415193, 32'h004, 32'h80000000, 32'd0,
                '{7'h13, 3'd5, 7'h20, 5'd4, 32'h80000000, 32'h404, 32'h404, 32'h004, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{32'h123453B7, 32'h100, 32'hDEADBEEF, 32'd0,
                '{7'h37, 3'd5, 7'h00, 5'd0, 32'h0, 32'h12345000, 32'h12345000, 32'h100, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{32'h12345397, 32'h100, 32'hDEADBEEF, 32'd0,
                '{7'h17, 3'd5, 7'h00, 5'd0, 32'h100, 32'h12345000, 32'h12345000, 32'h100, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{32'h0000007F, 32'h200, 32'h1234, 32'h5678,
                '{7'h00, 3'd0, 7'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{32'h00100013, 32'h204, 32'd7, 32'd0,
                '{7'h13, 3'd0, 7'h00, 5'd0, 32'd7, 32'd1, 32'd1, 32'h204, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{32'hFE209CE3, 32'h300, 32'h11, 32'h22,
                '{7'h63, 3'd1, 7'h00, 5'd0, 32'h11, 32'h22, 32'hFFFFFFF8, 32'h300, 5'd25, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{32'hFE512E23, 32'h304, 32'h1000, 32'h55,
                '{7'h23, 3'd2, 7'h00, 5'd0, 32'h1000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h304, 5'd28, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[8] = '{32'h4020D1B3, 32'h308, 32'hF0000000, 32'h27,
                '{7'h33, 3'd5, 7'h20, 5'd7, 32'hF0000000, 32'h27, 32'h0, 32'h308, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    rst_b = '0;
    rst_b.pc = RPC;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("reset_valid", 192'(bus.out_valid), 192'(1'b0));
    chk("reset_bundle", 192'(observed()), 192'(rst_b));
    @(negedge clk);
    reset = 1'b0;
    exp_full = 1'b0;
    exp_b = rst_b;

    // Directed table, streamed back to back at full throughput.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 192'(bus.out_valid), 192'(1'b1));
      chk($sformatf("vec%0d_bundle", i), 192'(observed()), 192'(vecs[i].exp));
      @(negedge clk);
    end
    exp_full = 1'b1;
    exp_b = vecs[8].exp;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();

    // Back-pressure: A accepted, B waits through a 3-cycle stall, then follows A.
    drive(1'b1, 1'b0, 1'b0, 32'hFFD08293, 32'h400, 32'd10, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h123453B7, 32'h404, 32'd1, 32'd2);
      step();
      chk("stall_pc_A", 192'(bus.out_pc), 192'(32'h400));
    end
    drive(1'b1, 1'b1, 1'b0, 32'h123453B7, 32'h404, 32'd1, 32'd2);
    step();
    chk("after_stall_pc_B", 192'(bus.out_pc), 192'(32'h404));
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();

    // Reset while full and stalled drops the bundle immediately.
    drive(1'b1, 1'b0, 1'b0, 32'h00500093, 32'h500, 32'd3, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    reset = 1'b1;
    #1;
    chk("midstall_reset_valid", 192'(bus.out_valid), 192'(1'b0));
    chk("midstall_reset_bundle", 192'(observed()), 192'(rst_b));
    exp_full = 1'b0;
    exp_b = rst_b;
    @(negedge clk);
    reset = 1'b0;

    // Flush while full with a concurrent valid input.
    drive(1'b1, 1'b1, 1'b0, 32'h00100013, 32'h600, 32'd9, 32'd0);
    step();
    drive(1'b1, 1'b1, 1'b1, 32'h0000006F, 32'h604, 32'd0, 32'd0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();

    // Random traffic with random back-pressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(7, 0) != 0) w[6:0] = ops[$urandom_range(8, 0)];
      drive($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, $urandom_range(15, 0) == 0,
            w, {$urandom, 2'b00} >> 2 << 2, $urandom, $urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
